// File: rtl/mips_pkg.sv
// Shared pipeline constants for the MIPS datapath.
// Used by the pipeline register blocks and the writeback/register-file stage.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_mux.sv
// Writeback result select: load data or ALU result.
// Also instanced by the forwarding path so both agree on the W-stage value.
module wb_mux
    import mips_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] y
);

    assign y = sel ? in1 : in0;

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB consumer: selects the writeback result and commits it to the register file.
// Provides two combinational decode read ports with same-cycle write bypass.
module wb_regfile #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regwrite_W,
    input  logic              memtoreg_W,
    input  logic [DATA_W-1:0] read_data_W,
    input  logic [DATA_W-1:0] aluout_W,
    input  logic [ADDR_W-1:0] writereg_W,
    input  logic [ADDR_W-1:0] ra1_D,
    input  logic [ADDR_W-1:0] ra2_D,
    output logic [DATA_W-1:0] rd1_D,
    output logic [DATA_W-1:0] rd2_D,
    output logic [DATA_W-1:0] result_W,
    output logic [CNT_W-1:0]  wb_count
);
    import mips_pkg::*;

    localparam int                NREGS    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREGS];
    logic              commit;

    wb_mux #(.W(DATA_W)) u_wb_mux (
        .sel (memtoreg_W),
        .in0 (aluout_W),
        .in1 (read_data_W),
        .y   (result_W)
    );

    // Register 0 is never written, so it holds the zero it got at reset.
    assign commit = regwrite_W && (writereg_W != ZERO_IDX);

    // NOTE: the array is reset explicitly so no read can ever return X; this
    // forces flops rather than a RAM macro, which is fine at 32 entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wb_count <= '0;
        end else if (commit) begin
            // NOTE: non-blocking so every reader this edge sees the old value.
            regs[writereg_W] <= result_W;
            wb_count         <= wb_count + CNT_W'(1);
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst,
        input logic              we,
        input logic [ADDR_W-1:0] wr_idx,
        input logic [DATA_W-1:0] wr_data,
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored
    );
        if (rst || ra == ZERO_IDX) begin
            return '0;
        end else if (we && wr_idx == ra) begin
            return wr_data;
        end
        return stored;
    endfunction

    always_comb begin
        rd1_D = read_port(reset, regwrite_W, writereg_W, result_W, ra1_D, regs[ra1_D]);
        rd2_D = read_port(reset, regwrite_W, writereg_W, result_W, ra2_D, regs[ra2_D]);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: reference model plus scoreboard of expected outputs.
// Inputs change on negedge; outputs are sampled 1 time unit later.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    typedef enum logic [1:0] {P_RD1, P_RD2, P_RES, P_CNT} port_e;
    typedef struct {
        string       tag;
        port_e       port;
        logic [31:0] exp;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          regwrite_W;
    logic          memtoreg_W;
    logic [DW-1:0] read_data_W;
    logic [DW-1:0] aluout_W;
    logic [AW-1:0] writereg_W;
    logic [AW-1:0] ra1_D;
    logic [AW-1:0] ra2_D;
    logic [DW-1:0] rd1_D;
    logic [DW-1:0] rd2_D;
    logic [DW-1:0] result_W;
    logic [CW-1:0] wb_count;

    exp_t          sb[$];
    logic [DW-1:0] m_regs [32];
    logic [CW-1:0] m_cnt;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] vals [17];

    wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .regwrite_W  (regwrite_W),
        .memtoreg_W  (memtoreg_W),
        .read_data_W (read_data_W),
        .aluout_W    (aluout_W),
        .writereg_W  (writereg_W),
        .ra1_D       (ra1_D),
        .ra2_D       (ra2_D),
        .rd1_D       (rd1_D),
        .rd2_D       (rd2_D),
        .result_W    (result_W),
        .wb_count    (wb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input port_e port, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Compare every queued expectation against the settled outputs.
    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.port)
                P_RD1:   got = rd1_D;
                P_RD2:   got = rd2_D;
                P_RES:   got = result_W;
                default: got = 32'(wb_count);
            endcase
            check(e.tag, got, e.exp);
        end
    endtask

    function automatic logic [DW-1:0] m_result();
        return memtoreg_W ? read_data_W : aluout_W;
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] ra);
        if (reset || ra == 0) return '0;
        if (regwrite_W && writereg_W == ra) return m_result();
        return m_regs[ra];
    endfunction

    // Advance one clock, updating the model with the inputs present at the edge.
    task automatic tick();
        logic          c;
        logic [AW-1:0] idx;
        logic [DW-1:0] d;
        c   = !reset && regwrite_W && writereg_W != 0;
        idx = writereg_W;
        d   = m_result();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_cnt = '0;
        end else if (c) begin
            m_regs[idx] = d;
            m_cnt       = m_cnt + 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        regwrite_W  = 1'b0;
        memtoreg_W  = 1'b0;
        read_data_W = '0;
        aluout_W    = '0;
        writereg_W  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 'x;
        m_cnt = 'x;
        reset = 1'b1;
        ra1_D = '0;
        ra2_D = '0;
        idle();
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;

        // Post-reset: every register reads zero on both ports.
        for (int r = 0; r < 32; r++) begin
            ra1_D = AW'(r);
            ra2_D = AW'(31 - r);
            push($sformatf("rst_rd1[%0d]", r), P_RD1, 32'h0);
            push($sformatf("rst_rd2[%0d]", 31 - r), P_RD2, 32'h0);
            drain();
        end
        push("rst_cnt", P_CNT, 32'd0);
        drain();

        // ALU write to r8 with same-cycle bypass.
        regwrite_W = 1'b1;
        aluout_W   = 32'h1234_5678;
        writereg_W = 5'd8;
        ra1_D      = 5'd8;
        push("byp_rd1", P_RD1, 32'h1234_5678);
        push("byp_res", P_RES, m_result());
        drain();
        tick();
        idle();
        push("r8_rd1", P_RD1, 32'h1234_5678);
        push("r8_cnt", P_CNT, 32'd1);
        drain();

        // Load path to r31.
        regwrite_W  = 1'b1;
        memtoreg_W  = 1'b1;
        read_data_W = 32'hDEAD_BEEF;
        aluout_W    = 32'h1;
        writereg_W  = 5'd31;
        ra2_D       = 5'd8;
        push("ld_res", P_RES, 32'hDEAD_BEEF);
        push("ld_rd2_other", P_RD2, 32'h1234_5678);
        drain();
        tick();
        idle();
        ra2_D = 5'd31;
        push("r31_rd2", P_RD2, 32'hDEAD_BEEF);
        push("r31_cnt", P_CNT, 32'd2);
        drain();

        // Writes to r0 are dropped and not counted.
        regwrite_W = 1'b1;
        aluout_W   = 32'hFFFF_FFFF;
        writereg_W = 5'd0;
        ra1_D      = 5'd0;
        push("r0_pre_rd1", P_RD1, 32'h0);
        drain();
        tick();
        idle();
        push("r0_post_rd1", P_RD1, 32'h0);
        push("r0_cnt", P_CNT, 32'd2);
        drain();

        // Reset beats a concurrent commit; the retried write then lands.
        reset      = 1'b1;
        regwrite_W = 1'b1;
        aluout_W   = 32'hAA;
        writereg_W = 5'd5;
        ra1_D      = 5'd5;
        push("rstw_rd1", P_RD1, 32'h0);
        drain();
        tick();
        reset      = 1'b0;
        regwrite_W = 1'b0;
        push("rstw_r5", P_RD1, 32'h0);
        push("rstw_r31", P_RD2, 32'h0);
        push("rstw_cnt", P_CNT, 32'd0);
        drain();
        regwrite_W = 1'b1;
        tick();
        idle();
        push("retry_r5", P_RD1, 32'hAA);
        push("retry_cnt", P_CNT, 32'd1);
        drain();

        // Counter wrap: clear, then 16 commits to r1..r16.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            vals[i]    = $urandom();
            regwrite_W = 1'b1;
            aluout_W   = vals[i];
            writereg_W = AW'(i);
            ra1_D      = AW'(i);
            ra2_D      = AW'(i);
            push($sformatf("wr_byp1[%0d]", i), P_RD1, vals[i]);
            push($sformatf("wr_byp2[%0d]", i), P_RD2, vals[i]);
            drain();
            tick();
            push($sformatf("wrap_cnt[%0d]", i), P_CNT, 32'(i % 16));
            drain();
        end
        idle();
        for (int i = 1; i <= 16; i++) begin
            ra1_D = AW'(i);
            ra2_D = AW'(17 - i);
            push($sformatf("rb_rd1[%0d]", i), P_RD1, vals[i]);
            push($sformatf("rb_rd2[%0d]", 17 - i), P_RD2, vals[17 - i]);
            push($sformatf("rb_m1[%0d]", i), P_RD1, m_read(ra1_D));
            drain();
        end
        push("final_cnt", P_CNT, 32'(m_cnt));
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: takes the W-stage control and data, selects the writeback result, and commits it to the 32-entry architectural register file.
- Serves the two decode-stage read ports, with same-cycle write-to-read bypass, so no separate negedge write is needed.
- Keeps a committed-write counter for debug and performance monitoring.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width (2^ADDR_W entries).
- CNT_W, 32, width of the writeback counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- regwrite_W  in  1  W-stage register write enable.
- memtoreg_W  in  1  1 selects read_data_W as result, 0 selects aluout_W.
- read_data_W  in  DATA_W  load data from MEM/WB.
- aluout_W  in  DATA_W  ALU result from MEM/WB.
- writereg_W  in  ADDR_W  destination register index.
- ra1_D  in  ADDR_W  decode read address, port 1 (rs).
- ra2_D  in  ADDR_W  decode read address, port 2 (rt).
- rd1_D  out  DATA_W  read data, port 1 (combinational).
- rd2_D  out  DATA_W  read data, port 2 (combinational).
- result_W  out  DATA_W  selected writeback value, also routed to the hazard/forwarding unit.
- wb_count  out  CNT_W  number of committed register writes.

Behaviour:
- Result select (combinational):
  - result_W = memtoreg_W ? read_data_W : aluout_W.
  - This output is independent of reset.
- Commit:
  - Occurs at posedge clk when reset==0, regwrite_W==1 and writereg_W!=0.
  - Effect: regs[writereg_W] <= result_W.
- Register 0:
  - Writes to register 0 are discarded.
  - A read of register 0 returns 0.
  - Writes to register 0 are not counted.
- Reads (combinational), priority per port:
  1. reset==1 -> 0.
  2. ra==0 -> 0.
  3. regwrite_W && writereg_W==ra -> result_W (bypass; a new value is visible in the same cycle it is written).
  4. Otherwise regs[ra].
- Both ports may address the same register and may hit the bypass simultaneously; each resolves independently.
- Reset:
  - At posedge with reset==1, all registers 1..31 are set to 0 and wb_count is set to 0.
  - Reset has priority over a concurrent commit: the write is lost and not counted.
  - Reset asserted mid-stream leaves no partial state; the first commit occurs on the first posedge after reset deasserts.
- Post-reset output values: rd1_D=0 and rd2_D=0 (all registers are zero, unless a bypass is active); wb_count=0.
- wb_count:
  - Increments by 1 on each commit.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Latency:
  - Write to architectural state: 1 cycle.
  - Read: 0 cycles.
- No X propagation: all storage is reset; bypass compares only indices and enable.

Decomposition:
- Shared package mips_pkg: DATA_W, ADDR_W, the REG_ZERO=0 constant and the register-count constant; the pipeline register blocks use the same package.
- One sub-module, wb_mux: the 2:1 result select, reused by the forwarding path.
- The register array, bypass logic and counter stay in wb_regfile.

Test Plan:
- Reset held for 2 cycles, then released:
  - Every ra1_D/ra2_D value 0..31 -> rd=0.
  - wb_count=0.
- regwrite_W=1, memtoreg_W=0, aluout_W=0x1234_5678, writereg_W=8, with ra1_D=8 in the same cycle:
  - rd1_D=0x1234_5678 in the same cycle (bypass).
  - After the edge, regwrite_W=0 and rd1_D still reads 0x1234_5678.
  - wb_count=1.
- Load path: memtoreg_W=1, read_data_W=0xDEAD_BEEF, aluout_W=0x1, writereg_W=31:
  - result_W=0xDEAD_BEEF.
  - regs[31]=0xDEAD_BEEF after the edge.
- Write to register 0: regwrite_W=1, writereg_W=0, aluout_W=0xFFFF_FFFF:
  - ra1_D=0 gives rd1_D=0 both before and after the edge.
  - wb_count is unchanged.
- Reset with a concurrent commit: reset=1, regwrite_W=1, writereg_W=5, aluout_W=0xAA:
  - After the edge, regs[5]=0 and wb_count=0.
  - Next cycle with reset=0, the same write commits and wb_count=1.
- Counter wrap: CNT_W=4, 16 consecutive commits to registers 1..16:
  - wb_count sequence is 1..15, then 0.
  - Both ports read back all 16 values correctly.
